// File: rtl/ps2_poly_note_tracker.sv
// PS/2 set-2 scancode tracker: allocates up to NUM_CH held note keys to channels
// and drives a per-channel half-period count, with octave shift and drop detection.
module ps2_poly_note_tracker #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 18,
    parameter int OCT_MAX  = 3,
    localparam int OCT_W   = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         data_valid,
    input  logic [7:0]                   data,
    output logic [NUM_CH*PERIOD_W-1:0]   period,
    output logic [NUM_CH-1:0]            ch_active,
    output logic [OCT_W-1:0]             octave,
    output logic                         drop
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t                     state_r, state_nxt_s;
    logic [NUM_CH-1:0]          ch_valid_r, ch_valid_nxt_s;
    logic [2:0]                 ch_key_r     [NUM_CH];
    logic [2:0]                 ch_key_nxt_s [NUM_CH];
    logic [OCT_W-1:0]           octave_r, octave_nxt_s;
    logic                       drop_r, drop_nxt_s;
    logic [NUM_CH*PERIOD_W-1:0] period_r, period_nxt_s;

    logic                       do_make_s, do_break_s;
    logic                       is_note_s;
    logic [2:0]                 note_idx_s;
    logic                       hit_s, free_found_s;
    logic [CH_W-1:0]            free_ch_s;

    // Returns {is_note, key_index} for a scancode.
    function automatic logic [3:0] decode_note(input logic [7:0] code);
        logic [3:0] res;
        case (code)
            8'h1C:   res = 4'b1_000;
            8'h1D:   res = 4'b1_001;
            8'h1B:   res = 4'b1_010;
            8'h23:   res = 4'b1_011;
            8'h24:   res = 4'b1_100;
            8'h2B:   res = 4'b1_101;
            8'h2D:   res = 4'b1_110;
            8'h2C:   res = 4'b1_111;
            default: res = 4'b0_000;
        endcase
        return res;
    endfunction

    // Base half-period, in clk counts, at octave shift 0.
    function automatic logic [17:0] base_period(input logic [2:0] idx);
        logic [17:0] res;
        case (idx)
            3'd0:    res = 18'd227273;
            3'd1:    res = 18'd214592;
            3'd2:    res = 18'd202429;
            3'd3:    res = 18'd190840;
            3'd4:    res = 18'd180505;
            3'd5:    res = 18'd170068;
            3'd6:    res = 18'd160722;
            3'd7:    res = 18'd151515;
            default: res = 18'd0;
        endcase
        return res;
    endfunction

    assign {is_note_s, note_idx_s} = decode_note(data);

    // Prefix FSM next state; classifies the current byte as make, break or discard.
    always_comb begin
        state_nxt_s = state_r;
        do_make_s   = 1'b0;
        do_break_s  = 1'b0;
        if (data_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (data == 8'hF0) begin
                        state_nxt_s = ST_BRK;
                    end else if (data == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        do_make_s = 1'b1;
                    end
                end
                ST_BRK: begin
                    do_break_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_EXT: begin
                    if (data == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT_BRK: state_nxt_s = ST_IDLE;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Search for an existing holder of the key and the lowest-index free channel.
    always_comb begin
        hit_s        = 1'b0;
        free_found_s = 1'b0;
        free_ch_s    = {CH_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid_r[i] && (ch_key_r[i] == note_idx_s)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
            if (!free_found_s && !ch_valid_r[i]) begin
                free_found_s = 1'b1;
                free_ch_s    = CH_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Channel table, octave and drop next state.
    always_comb begin
        ch_valid_nxt_s = ch_valid_r;
        ch_key_nxt_s   = ch_key_r;
        octave_nxt_s   = octave_r;
        drop_nxt_s     = 1'b0;
        if (do_make_s && is_note_s) begin
            if (hit_s) begin
                drop_nxt_s = 1'b0;
            end else if (free_found_s) begin
                ch_valid_nxt_s[free_ch_s] = 1'b1;
                ch_key_nxt_s[free_ch_s]   = note_idx_s;
            end else begin
                drop_nxt_s = 1'b1;
            end
        end else if (do_break_s && is_note_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid_r[i] && (ch_key_r[i] == note_idx_s)) begin
                    ch_valid_nxt_s[i] = 1'b0;
                end else begin
                    ch_valid_nxt_s[i] = ch_valid_r[i];
                end
            end
        end else if (do_make_s && (data == 8'h22)) begin
            if (octave_r != OCT_W'(OCT_MAX)) begin
                octave_nxt_s = octave_r + OCT_W'(1);
            end else begin
                octave_nxt_s = octave_r;
            end
        end else if (do_make_s && (data == 8'h1A)) begin
            if (octave_r != {OCT_W{1'b0}}) begin
                octave_nxt_s = octave_r - OCT_W'(1);
            end else begin
                octave_nxt_s = octave_r;
            end
        end else begin
            drop_nxt_s = 1'b0;
        end
    end

    // Periods follow the registered table, so they settle one edge after it.
    always_comb begin
        period_nxt_s = {(NUM_CH*PERIOD_W){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid_r[i]) begin
                period_nxt_s[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(base_period(ch_key_r[i]) >> octave_r);
            end else begin
                period_nxt_s[i*PERIOD_W +: PERIOD_W] = {PERIOD_W{1'b0}};
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ch_valid_r <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                ch_key_r[i] <= 3'd0;
            end
            octave_r   <= {OCT_W{1'b0}};
            drop_r     <= 1'b0;
            period_r   <= {(NUM_CH*PERIOD_W){1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            ch_valid_r <= ch_valid_nxt_s;
            ch_key_r   <= ch_key_nxt_s;
            octave_r   <= octave_nxt_s;
            drop_r     <= drop_nxt_s;
            period_r   <= period_nxt_s;
        end
    end

    assign period    = period_r;
    assign ch_active = ch_valid_r;
    assign octave    = octave_r;
    assign drop      = drop_r;

endmodule

// File: tb/tb_ps2_poly_note_tracker.sv
// Self-checking bench for ps2_poly_note_tracker: a reference model pushes expected
// outputs per driven cycle and a scoreboard process pops and compares them.
module tb_ps2_poly_note_tracker;

    localparam int NUM_CH  = 4;
    localparam int PW      = 18;
    localparam int OCT_MAX = 3;

    logic                 clk;
    logic                 reset;
    logic                 data_valid;
    logic [7:0]           data;
    logic [NUM_CH*PW-1:0] period;
    logic [NUM_CH-1:0]    ch_active;
    logic [1:0]           octave;
    logic                 drop;

    ps2_poly_note_tracker #(.NUM_CH(NUM_CH), .PERIOD_W(PW), .OCT_MAX(OCT_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_valid (data_valid),
        .data       (data),
        .period     (period),
        .ch_active  (ch_active),
        .octave     (octave),
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]    act;
        logic [1:0]           oct;
        logic                 drp;
        logic [NUM_CH*PW-1:0] per;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model
    int codes [8] = '{'h1C, 'h1D, 'h1B, 'h23, 'h24, 'h2B, 'h2D, 'h2C};
    int bases [8] = '{227273, 214592, 202429, 190840, 180505, 170068, 160722, 151515};
    int m_state;
    bit m_valid [NUM_CH];
    int m_key   [NUM_CH];
    int m_oct;
    bit m_drop;

    function automatic int key_of(input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            if (codes[k] == int'(d)) return k;
        end
        return -1;
    endfunction

    function automatic logic [NUM_CH*PW-1:0] model_period();
        logic [NUM_CH*PW-1:0] p;
        int v;
        p = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v = m_valid[c] ? (bases[m_key[c]] >> m_oct) : 0;
            p[c*PW +: PW] = v[PW-1:0];
        end
        return p;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_oct   = 0;
        m_drop  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_valid[c] = 1'b0;
            m_key[c]   = 0;
        end
    endtask

    task automatic model_make(input logic [7:0] d);
        int k;
        bit done;
        k = key_of(d);
        if (k >= 0) begin
            done = 1'b0;
            for (int c = 0; c < NUM_CH; c++) if (m_valid[c] && m_key[c] == k) done = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!done && !m_valid[c]) begin
                    m_valid[c] = 1'b1;
                    m_key[c]   = k;
                    done       = 1'b1;
                end
            end
            if (!done) m_drop = 1'b1;
        end
        if (d == 8'h22 && m_oct < OCT_MAX) m_oct++;
        if (d == 8'h1A && m_oct > 0) m_oct--;
    endtask

    task automatic model_break(input logic [7:0] d);
        int k;
        k = key_of(d);
        for (int c = 0; c < NUM_CH; c++) begin
            if (k >= 0 && m_valid[c] && m_key[c] == k) m_valid[c] = 1'b0;
        end
    endtask

    // Drives one cycle and queues what the DUT must show after the coming edge.
    task automatic drive(input logic v, input logic [7:0] d);
        exp_t e;
        e.per  = model_period();
        m_drop = 1'b0;
        if (v) begin
            case (m_state)
                0: begin
                    if (d == 8'hF0) m_state = 1;
                    else if (d == 8'hE0) m_state = 2;
                    else model_make(d);
                end
                1: begin model_break(d); m_state = 0; end
                2: m_state = (d == 8'hF0) ? 3 : 0;
                default: m_state = 0;
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) e.act[c] = m_valid[c];
        e.oct = 2'(m_oct);
        e.drp = m_drop;
        sb_q.push_back(e);
        data_valid = v;
        data       = d;
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: compares each queued expectation just after its edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (ch_active !== e.act) begin
                miscompares++;
                $display("FAIL sb_ch_active: got %b expected %b at %0t", ch_active, e.act, $time);
            end
            vectors++;
            if (octave !== e.oct) begin
                miscompares++;
                $display("FAIL sb_octave: got %0d expected %0d at %0t", octave, e.oct, $time);
            end
            vectors++;
            if (drop !== e.drp) begin
                miscompares++;
                $display("FAIL sb_drop: got %b expected %b at %0t", drop, e.drp, $time);
            end
            vectors++;
            if (period !== e.per) begin
                miscompares++;
                $display("FAIL sb_period: got %h expected %h at %0t", period, e.per, $time);
            end
        end
    end

    task automatic do_reset();
        data_valid = 1'b0;
        data       = 8'h00;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (ch_active !== 4'b0000 || octave !== 2'd0 || drop !== 1'b0 || period !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got act=%b oct=%0d drop=%b per=%h expected all zero",
                     ch_active, octave, drop, period);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        sb_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 8'h00);
    endtask

    task automatic test_alloc();
        do_reset();
        drive(1'b1, 8'h1C);
        vectors++;
        if (ch_active !== 4'b0001) begin
            miscompares++;
            $display("FAIL alloc_act0: got %b expected 0001", ch_active);
        end
        drive(1'b0, 8'h00);
        vectors++;
        if (period[0 +: PW] !== 18'd227273) begin
            miscompares++;
            $display("FAIL alloc_per0: got %0d expected 227273", period[0 +: PW]);
        end
        drive(1'b1, 8'h1D);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0011 || period[PW +: PW] !== 18'd214592) begin
            miscompares++;
            $display("FAIL alloc_ch1: got act=%b per=%0d expected 0011/214592", ch_active, period[PW +: PW]);
        end
    endtask

    task automatic test_release_realloc();
        drive(1'b1, 8'hF0);
        drive(1'b1, 8'h1C);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0010 || period[0 +: PW] !== 18'd0) begin
            miscompares++;
            $display("FAIL release: got act=%b per0=%0d expected 0010/0", ch_active, period[0 +: PW]);
        end
        drive(1'b1, 8'h1B);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0011 || period[0 +: PW] !== 18'd202429 || period[PW +: PW] !== 18'd214592) begin
            miscompares++;
            $display("FAIL realloc: got act=%b per0=%0d per1=%0d expected 0011/202429/214592",
                     ch_active, period[0 +: PW], period[PW +: PW]);
        end
    endtask

    task automatic test_back_to_back_drop();
        do_reset();
        drive(1'b1, 8'h1C);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'h1B);
        drive(1'b1, 8'h23);
        drive(1'b1, 8'h24);
        vectors++;
        if (drop !== 1'b1 || ch_active !== 4'b1111) begin
            miscompares++;
            $display("FAIL drop_pulse: got drop=%b act=%b expected 1/1111", drop, ch_active);
        end
        drive(1'b0, 8'h00);
        vectors++;
        if (drop !== 1'b0 || period[3*PW +: PW] !== 18'd190840) begin
            miscompares++;
            $display("FAIL drop_clear: got drop=%b per3=%0d expected 0/190840", drop, period[3*PW +: PW]);
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic test_repeat();
        do_reset();
        drive(1'b1, 8'h1C);
        drive(1'b1, 8'h1C);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0001) begin
            miscompares++;
            $display("FAIL repeat: got %b expected 0001", ch_active);
        end
    endtask

    task automatic test_octave();
        do_reset();
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h23);
        drive(1'b0, 8'h00);
        vectors++;
        if (octave !== 2'd2 || period[0 +: PW] !== 18'd47710) begin
            miscompares++;
            $display("FAIL octave2: got oct=%0d per=%0d expected 2/47710", octave, period[0 +: PW]);
        end
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'hF0);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        vectors++;
        if (octave !== 2'd3 || period[0 +: PW] !== 18'd23855) begin
            miscompares++;
            $display("FAIL octave_sat: got oct=%0d per=%0d expected 3/23855", octave, period[0 +: PW]);
        end
        drive(1'b1, 8'h1A);
        drive(1'b0, 8'h00);
        do_reset();
        drive(1'b1, 8'h1A);
        drive(1'b0, 8'h00);
        vectors++;
        if (octave !== 2'd0) begin
            miscompares++;
            $display("FAIL octave_floor: got %0d expected 0", octave);
        end
    endtask

    task automatic test_ext_and_mid_reset();
        do_reset();
        drive(1'b1, 8'hE0);
        drive(1'b1, 8'h1C);
        drive(1'b1, 8'hE0);
        drive(1'b1, 8'hF0);
        drive(1'b1, 8'h1C);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'hFA);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0000) begin
            miscompares++;
            $display("FAIL ext_ignored: got %b expected 0000", ch_active);
        end
        drive(1'b1, 8'hF0);
        drive(1'b0, 8'h00);
        do_reset();
        drive(1'b1, 8'h2C);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0001 || period[0 +: PW] !== 18'd151515) begin
            miscompares++;
            $display("FAIL mid_reset_make: got act=%b per=%0d expected 0001/151515", ch_active, period[0 +: PW]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 8'h1C);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'h1B);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        vectors++;
        if (ch_active !== 4'b0111) begin
            miscompares++;
            $display("FAIL async_pre: got %b expected 0111", ch_active);
        end
        do_reset();
        drive(1'b0, 8'h00);
    endtask

    initial begin
        reset      = 1'b0;
        data_valid = 1'b0;
        data       = 8'h00;
        model_reset();
        @(posedge clk);
        #2;
        test_reset();
        test_alloc();
        test_release_realloc();
        test_back_to_back_drop();
        test_repeat();
        test_octave();
        test_ext_and_mid_reset();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_poly_note_tracker.md
Name: ps2_poly_note_tracker

Overview:
- Successor to the single-key scancode-to-period decoder.
- Consumes PS/2 set-2 scancode bytes and tracks make and break (F0) prefixes. Ignores extended (E0) codes.
- Allocates up to NUM_CH simultaneously held note keys to channels and outputs a per-channel half-period count for the tone generators.
- Adds octave up/down keys, and detects and drops notes when no channel is free.

Parameters:
- NUM_CH, 4, number of polyphony channels (1..8).
- PERIOD_W, 18, width of each period field.
- OCT_MAX, 3, highest octave shift; the octave register saturates in 0..OCT_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- data_valid  input  1  one-cycle strobe; data is a complete received scancode byte.
- data  input  8  scancode byte.
- period  output  NUM_CH*PERIOD_W  channel i occupies bits [i*PERIOD_W +: PERIOD_W]; 0 when the channel is inactive.
- ch_active  output  NUM_CH  bit i is 1 while channel i holds a key.
- octave  output  $clog2(OCT_MAX+1)  current octave shift.
- drop  output  1  one-cycle pulse when a note make finds no free channel.

Behaviour:
- Reset (async assert, sync release): prefix FSM = IDLE; all channels free; octave = 0; period = 0; ch_active = 0; drop = 0.
- Note key table, base periods in clk counts:
  - 0x1C = 227273
  - 0x1D = 214592
  - 0x1B = 202429
  - 0x23 = 190840
  - 0x24 = 180505
  - 0x2B = 170068
  - 0x2D = 160722
  - 0x2C = 151515
  - Each channel stores a 3-bit key index plus a valid bit.
- Octave keys: 0x1A = down, 0x22 = up. Only the make code acts, and it saturates at 0 / OCT_MAX. The break code is ignored.
- Prefix FSM, advancing only on data_valid:
  - IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte -> process as make, stay IDLE.
  - BRK: any byte -> process as break, go to IDLE.
  - EXT: 0xF0 -> EXT_BRK; any other byte -> discard, go to IDLE.
  - EXT_BRK: any byte -> discard, go to IDLE.
- Make of a note key:
  - If the key is already held on some channel (typematic repeat), no change.
  - Else allocate the lowest-index free channel.
  - If all channels are busy, no change and drop = 1 for one cycle.
- Break of a note key: free the channel holding it. Break of a key not held: no effect.
- Unknown codes (including 0xAA and 0xFA) are ignored, with the FSM transitions above still applied.
- Timing, with data_valid sampled at edge k:
  - FSM, channel table, octave and drop update at edge k.
  - period updates at edge k+1.
  - For each channel: period = ch_valid ? (base[key] >> octave) : 0, truncated to PERIOD_W.
- An octave change retunes all held channels at the next edge; keys stay on their channels.
- data_valid low: state holds; drop is 0.
- Back-to-back data_valid on consecutive cycles must be processed, one byte per cycle.
- Reset mid-sequence, including in BRK or EXT, discards the pending prefix. The next byte is treated from IDLE.

Test Plan:
- Reset, then 0x1C -> ch_active=0001, period ch0 = 227273 one cycle after ch_active; 0x1D -> ch_active=0011, ch1 = 214592.
- With ch0=0x1C and ch1=0x1D, send F0,1C -> ch_active=0010, ch0 period = 0; then 0x1B -> ch0 reallocated, ch0 = 202429, ch1 unchanged.
- Makes 1C,1D,1B,23 then 24 -> ch_active=1111, drop pulses exactly one cycle on the 0x24 byte, no period changes; 1C,1C (repeat) before any release -> only one channel used.
- 0x22 twice, then 0x23 -> octave=2, period 47710; 0x22 three more times -> octave saturates at 3, held period becomes 23855; 0x1A with octave=0 stays 0.
- E0,1C and E0,F0,1C -> no channel change; then F0 held briefly and reset asserted mid-break, then 0x2C -> allocated as make, ch0 = 151515.
- Async reset asserted between clock edges while 3 notes are held -> all outputs 0 immediately, without waiting for a clock edge.
